axi_rng_fetch_ctrl: RTL
=======================

# axi_rng_fetch_ctrl

AXI master controller that sequences the RNG register slave: on a start pulse it writes a seed to the slave's seed register, then issues a programmed number of single-beat reads of the RNG data register. Returned words are buffered in a small FIFO and presented to a downstream consumer on a valid/ready stream. It sits between the RNG slave's AXI port and any on-chip consumer of random words. Issue is throttled by FIFO space, and AXI errors are reported.

## Interface
- DEPTH, 4: output FIFO entries, power of two, 2..16.
- RNG_BASE, 32'h0000_0000: slave base address. Seed register is RNG_BASE+0x008; data register is RNG_BASE+0x000.
- AXI_ID, 16'h0000: value driven on ARID and AWID.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request; sampled only when busy=0.
- seed  in  32  seed value, captured on an accepted start.
- count  in  8  number of random words to fetch, captured on an accepted start; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence ends (normal or abort).
- error  out  1  sticky; set by a non-OKAY BRESP or RRESP; cleared on the next accepted start.
- out_valid  out  1  FIFO non-empty.
- out_data  out  32  FIFO head word, first-word fall-through.
- out_ready  in  1  consumer pop; a pop occurs when out_valid && out_ready.
- AXI master channels, widths matching the RNG slave:
  - AR channel: ARID[15:0], ARADDR[31:0], ARLEN[3:0], ARSIZE[2:0], ARBURST[1:0], ARVALID out; ARREADY in.
  - R channel: RID[15:0], RDATA[31:0], RRESP[1:0], RLAST, RVALID in; RREADY out.
  - AW channel: AWID[15:0], AWADDR[31:0], AWLEN[3:0], AWSIZE[2:0], AWBURST[1:0], AWVALID out; AWREADY in.
  - W channel: WDATA[31:0], WSTRB[7:0], WVALID out; WREADY in.
  - B channel: BID[15:0], BRESP[1:0], BVALID in; BREADY out.

## Operation
- Constant outputs: ARLEN=AWLEN=0, ARSIZE=AWSIZE=3'b010, ARBURST=AWBURST=2'b01, WSTRB=8'h0F, ARID=AWID=AXI_ID, ARADDR=RNG_BASE, AWADDR=RNG_BASE+32'h8.
- State machine states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA.
- IDLE, start && !busy:
  - Capture seed to WDATA and count to a remaining counter; clear error.
  - Go to WR_REQ.
  - start while busy=1 is ignored.
- WR_REQ:
  - Assert AWVALID and WVALID together.
  - Each valid drops independently in the cycle after its ready is sampled high.
  - When both handshakes are complete, go to WR_RESP.
- WR_RESP:
  - Assert BREADY.
  - On BVALID with BRESP!=0: set error and abort.
  - On BVALID with BRESP==0: go to RD_REQ, or finish if remaining==0.
- RD_REQ:
  - Assert ARVALID only while FIFO occupancy < DEPTH.
  - Once asserted, hold ARVALID until ARREADY is sampled high.
  - After the handshake, go to RD_DATA.
- RD_DATA:
  - Assert RREADY.
  - On RVALID: push RDATA into the FIFO (even when RRESP!=0) and decrement remaining.
  - If RRESP!=0: set error and abort.
  - Otherwise go to RD_REQ if remaining!=0, else finish.
- Finish and abort both return to IDLE, pulse done for one cycle, and drop busy in the same cycle.
- At most one AXI transaction outstanding; RID and BID are ignored.
- FIFO:
  - Occupancy counter is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave occupancy unchanged; with a full FIFO this is legal.
  - The FIFO is not flushed on start, only on reset.
- remaining is an 8-bit down-counter and never underflows.

## Timing
- Reset values:
  - busy, done, error, out_valid = 0; out_data = 0.
  - ARVALID, AWVALID, WVALID, RREADY, BREADY = 0; WDATA = 0.
  - FIFO empty, state IDLE.
- Reset mid-operation: immediate return to IDLE with every output at its reset value; the in-flight AXI transaction is abandoned.
- busy rises on the cycle after start is sampled; AWVALID and WVALID rise in the same cycle.
- A pushed word is visible on out_valid/out_data the cycle after the R handshake.
- done is coincident with busy falling.
- count=0: seed write only; done follows the B handshake.
- FIFO full in RD_REQ: ARVALID stays low and the controller stalls indefinitely; no word is dropped.

## Test plan
- seed=0x1234, count=3, out_ready=1, RNG_BASE=0 -> one write with AWADDR=0x008, WDATA=0x1234, WSTRB=0x0F; three reads of 0x000; three words on out_data; slave read counter (0x00C) reads 3; done pulses once; error=0.
- count=6, out_ready=0 -> exactly 4 AR handshakes, then ARVALID held low with busy=1; raise out_ready -> remaining 2 reads; 6 words popped in order; done.
- RNG_BASE=0x100 -> BRESP=2'b10 on the seed write -> error=1, no ARVALID, done pulses; next start clears error.
- count=0 -> single write, zero reads, done after the B handshake, FIFO stays empty.
- start reasserted while busy=1 with a different seed/count -> ignored; original sequence completes unchanged.
- ARESETn low during RD_DATA with 2 words buffered -> all outputs at reset values, FIFO empty; a subsequent start with count=1 completes normally.

Source files
------------

// File: rtl/axi_rng_fetch_ctrl_if.sv
// AXI4 port between the RNG fetch controller (master) and the RNG register slave.
// Single-beat transfers only; widths follow the RNG slave.
interface axi_rng_fetch_ctrl_if;
    logic [15:0] ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;

    logic [15:0] RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    logic [15:0] AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;

    logic [31:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;

    logic [15:0] BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_rng_fetch_ctrl.sv
// Seeds the RNG slave, then fetches a programmed number of random words one read at a time
// into a small first-word-fall-through FIFO drained by a valid/ready consumer.
module axi_rng_fetch_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RNG_BASE = 32'h0000_0000,
    parameter logic [15:0] AXI_ID   = 16'h0000
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 start,
    input  logic [31:0]          seed,
    input  logic [7:0]           count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    input  logic                 out_ready,
    axi_rng_fetch_ctrl_if.master axi
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_OCC = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

    state_t        state_reg, state_next;
    logic          aw_done_reg, w_done_reg;
    logic [31:0]   wdata_reg;
    logic [7:0]    remaining_reg;
    logic          error_reg, done_reg;
    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   occ_reg;

    logic awvalid, wvalid, bready, arvalid, rready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic start_ok, seq_end, resp_err, push, pop;
    logic unused_axi;

    assign axi.ARID    = AXI_ID;
    assign axi.ARADDR  = RNG_BASE;
    assign axi.ARLEN   = 4'd0;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = arvalid;
    assign axi.RREADY  = rready;
    assign axi.AWID    = AXI_ID;
    assign axi.AWADDR  = RNG_BASE + 32'h8;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = awvalid;
    assign axi.WDATA   = wdata_reg;
    assign axi.WSTRB   = 8'h0F;
    assign axi.WVALID  = wvalid;
    assign axi.BREADY  = bready;

    // Only one transaction is ever outstanding, so response IDs carry no information.
    assign unused_axi = ^{axi.RID, axi.BID, axi.RLAST};

    assign aw_hs    = awvalid && axi.AWREADY;
    assign w_hs     = wvalid && axi.WREADY;
    assign b_hs     = bready && axi.BVALID;
    assign ar_hs    = arvalid && axi.ARREADY;
    assign r_hs     = rready && axi.RVALID;
    assign start_ok = start && (state_reg == IDLE);
    assign resp_err = (b_hs && (axi.BRESP != 2'b00)) || (r_hs && (axi.RRESP != 2'b00));

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign error = error_reg;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        seq_end    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = WR_REQ;
            end
            WR_REQ: begin
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    if ((axi.BRESP != 2'b00) || (remaining_reg == 8'd0)) seq_end = 1'b1;
                    else state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                if (ar_hs) state_next = RD_DATA;
            end
            RD_DATA: begin
                if (r_hs) begin
                    if ((axi.RRESP != 2'b00) || (remaining_reg <= 8'd1)) seq_end = 1'b1;
                    else state_next = RD_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (seq_end) state_next = IDLE;
    end

    // Occupancy cannot grow while in RD_REQ, so once ARVALID rises it stays up until ARREADY.
    always_comb begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (state_reg)
            WR_REQ: begin
                awvalid = !aw_done_reg;
                wvalid  = !w_done_reg;
            end
            WR_RESP: bready  = 1'b1;
            RD_REQ:  arvalid = (occ_reg < DEPTH_OCC);
            RD_DATA: rready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            wdata_reg     <= 32'h0;
            remaining_reg <= 8'd0;
            error_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= seq_end;
            if (state_reg != WR_REQ) begin
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
            end
            if (start_ok) begin
                wdata_reg     <= seed;
                remaining_reg <= count;
                error_reg     <= 1'b0;
            end else begin
                if (resp_err) error_reg <= 1'b1;
                if (r_hs && (remaining_reg != 8'd0)) remaining_reg <= remaining_reg - 8'd1;
            end
        end
    end

    // Output FIFO: a word with an error response is still kept so the consumer sees everything fetched.
    assign push      = r_hs;
    assign out_valid = (occ_reg != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_mem[rd_ptr_reg] : 32'h0;

    always_ff @(posedge ACLK) begin
        if (push) fifo_mem[wr_ptr_reg] <= axi.RDATA;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + (AW + 1)'(1);
                2'b01:   occ_reg <= occ_reg - (AW + 1)'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end
endmodule
